// File: rtl/cpu_step_1_if.sv
// rtl/cpu_step_1_if.sv - instruction-memory fetch bus between the fetch stage and imem.
interface cpu_step_1_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/cpu_step_1.sv
// rtl/cpu_step_1.sv - instruction fetch stage feeding the IF/ID register.
// Handles wait states, decode stalls via a one-word hold buffer, and redirects.
module cpu_step_1 #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  cpu_step_1_if.master     imem,
  output logic [WIDTH-1:0] instr_step_2,
  output logic [WIDTH-1:0] pc_step_2,
  output logic             valid_step_2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc2;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [WIDTH-1:0] w_buf_nxt;
  logic [WIDTH-1:0] w_instr_nxt;
  logic [WIDTH-1:0] w_pc2_nxt;
  logic             w_valid_nxt;

  logic             w_req;
  logic             w_ack;
  logic [WIDTH-1:0] w_redir_pc;
  logic [WIDTH-1:0] w_pc_inc;

  // DROP keeps presenting the old pc so the outstanding access can complete.
  assign w_req      = (r_state == FETCH) || (r_state == DROP);
  assign w_ack      = imem.imem_ack & w_req;
  assign w_redir_pc = {redirect_pc[WIDTH-1:2], 2'b00};
  assign w_pc_inc   = r_pc + WIDTH'(4);

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  assign instr_step_2 = r_instr;
  assign pc_step_2    = r_pc2;
  assign valid_step_2 = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_pending <= '0;
      r_buf     <= '0;
      r_instr   <= '0;
      r_pc2     <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pending <= w_pending_nxt;
      r_buf     <= w_buf_nxt;
      r_instr   <= w_instr_nxt;
      r_pc2     <= w_pc2_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending;
    w_buf_nxt     = r_buf;
    w_instr_nxt   = r_instr;
    w_pc2_nxt     = r_pc2;
    w_valid_nxt   = r_valid;

    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end

      FETCH: begin
        if (redirect) begin
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
          if (w_ack) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_pending_nxt = w_redir_pc;
            w_state_nxt   = DROP;
          end
        end else if (w_ack) begin
          if (stall) begin
            w_buf_nxt   = imem.imem_rdata;
            w_state_nxt = HOLD;
          end else begin
            w_instr_nxt = imem.imem_rdata;
            w_pc2_nxt   = r_pc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
          end
        end else if (!stall) begin
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        // r_pc still addresses the buffered word; it advances only on delivery.
        if (redirect) begin
          w_buf_nxt   = '0;
          w_pc_nxt    = w_redir_pc;
          w_instr_nxt = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_instr_nxt = r_buf;
          w_pc2_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = FETCH;
        end
      end

      DROP: begin
        w_instr_nxt = '0;
        w_valid_nxt = 1'b0;
        if (w_ack) begin
          w_pc_nxt    = redirect ? w_redir_pc : r_pending;
          w_state_nxt = FETCH;
        end else if (redirect) begin
          w_pending_nxt = w_redir_pc;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_step_1.sv
// tb/tb_cpu_step_1.sv - directed vector bench for cpu_step_1.
module tb_cpu_step_1;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc2;
    logic [31:0] instr;
  } vec_t;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_step_2;
  logic [31:0] pc_step_2;
  logic        valid_step_2;

  int n_tests;
  int n_fail;
  vec_t vecs[$];

  cpu_step_1_if #(.WIDTH(32)) bus ();

  cpu_step_1 #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem         (bus.master),
    .instr_step_2 (instr_step_2),
    .pc_step_2    (pc_step_2),
    .valid_step_2 (valid_step_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic a,
                     input logic [31:0] rd, input logic q, input logic [31:0] ad,
                     input logic v, input logic [31:0] p2, input logic [31:0] ins);
    vec_t x;
    x.stall = s; x.redir = r; x.rpc = rpc; x.ack = a; x.rdata = rd;
    x.req = q; x.addr = ad; x.valid = v; x.pc2 = p2; x.instr = ins;
    vecs.push_back(x);
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic [31:0] p2,
                               input logic [31:0] ins);
    chk({tag, " valid"}, {31'd0, valid_step_2}, {31'd0, v});
    chk({tag, " pc2"},   pc_step_2, p2);
    chk({tag, " instr"}, instr_step_2, ins);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;

    //   stall redir rpc           ack rdata              req addr           valid pc2            instr
    add(0, 0, 32'h0,         0, 32'h0,              0, 32'h0,         0, 32'h0,         32'h0);          // IDLE
    add(0, 0, 32'h0,         1, 32'h0 ^ K,          1, 32'h0,         1, 32'h0,         32'h0 ^ K);
    add(0, 0, 32'h0,         1, 32'h4 ^ K,          1, 32'h4,         1, 32'h4,         32'h4 ^ K);
    add(1, 0, 32'h0,         1, 32'h8 ^ K,          1, 32'h8,         1, 32'h4,         32'h4 ^ K);      // stall at ack of 8
    add(1, 0, 32'h0,         1, 32'hDEAD_BEEF,      0, 32'h0,         1, 32'h4,         32'h4 ^ K);      // HOLD, stray ack
    add(1, 0, 32'h0,         1, 32'hDEAD_BEEF,      0, 32'h0,         1, 32'h4,         32'h4 ^ K);
    add(1, 0, 32'h0,         0, 32'h0,              0, 32'h0,         1, 32'h4,         32'h4 ^ K);
    add(0, 0, 32'h0,         0, 32'h0,              0, 32'h0,         1, 32'h8,         32'h8 ^ K);
    add(0, 0, 32'h0,         0, 32'h0,              1, 32'hC,         0, 32'h8,         32'h0);          // wait states
    add(0, 0, 32'h0,         0, 32'h0,              1, 32'hC,         0, 32'h8,         32'h0);
    add(0, 0, 32'h0,         0, 32'h0,              1, 32'hC,         0, 32'h8,         32'h0);
    add(0, 0, 32'h0,         1, 32'hC ^ K,          1, 32'hC,         1, 32'hC,         32'hC ^ K);
    add(0, 1, 32'h102,       0, 32'h0,              1, 32'h10,        0, 32'hC,         32'h0);          // redirect while waiting
    add(0, 0, 32'h0,         0, 32'h0,              1, 32'h10,        0, 32'hC,         32'h0);
    add(0, 0, 32'h0,         1, 32'h10 ^ K,         1, 32'h10,        0, 32'hC,         32'h0);
    add(0, 0, 32'h0,         1, 32'h100 ^ K,        1, 32'h100,       1, 32'h100,       32'h100 ^ K);
    add(1, 0, 32'h0,         1, 32'h104 ^ K,        1, 32'h104,       1, 32'h100,       32'h100 ^ K);    // into HOLD
    add(1, 1, 32'h203,       0, 32'h0,              0, 32'h0,         0, 32'h100,       32'h0);          // redirect+stall in HOLD
    add(0, 0, 32'h0,         1, 32'h200 ^ K,        1, 32'h200,       1, 32'h200,       32'h200 ^ K);
    add(0, 1, 32'h300,       1, 32'h204 ^ K,        1, 32'h204,       0, 32'h200,       32'h0);          // redirect with ack
    add(0, 0, 32'h0,         1, 32'h300 ^ K,        1, 32'h300,       1, 32'h300,       32'h300 ^ K);
    add(0, 1, 32'h400,       0, 32'h0,              1, 32'h304,       0, 32'h300,       32'h0);          // to DROP
    add(1, 1, 32'h500,       0, 32'h0,              1, 32'h304,       0, 32'h300,       32'h0);
    add(0, 1, 32'h600,       1, 32'h304 ^ K,        1, 32'h304,       0, 32'h300,       32'h0);          // redirect with ack in DROP
    add(0, 0, 32'h0,         1, 32'h600 ^ K,        1, 32'h600,       1, 32'h600,       32'h600 ^ K);
    add(0, 1, 32'h700,       0, 32'h0,              1, 32'h604,       0, 32'h600,       32'h0);
    add(0, 1, 32'h800,       0, 32'h0,              1, 32'h604,       0, 32'h600,       32'h0);          // pending overwritten
    add(0, 0, 32'h0,         1, 32'h604 ^ K,        1, 32'h604,       0, 32'h600,       32'h0);
    add(0, 0, 32'h0,         1, 32'h800 ^ K,        1, 32'h800,       1, 32'h800,       32'h800 ^ K);
    add(0, 1, 32'hFFFF_FFFE, 1, 32'h804 ^ K,        1, 32'h804,       0, 32'h800,       32'h0);          // align + wrap
    add(0, 0, 32'h0,         1, 32'hFFFF_FFFC ^ K,  1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ K);
    add(0, 0, 32'h0,         1, 32'h0 ^ K,          1, 32'h0,         1, 32'h0,         32'h0 ^ K);
    add(0, 1, 32'h900,       0, 32'h0,              1, 32'h4,         0, 32'h0,         32'h0);          // to DROP for reset

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req", {31'd0, bus.imem_req}, 32'd0);
    check_outputs("reset", 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall            = vecs[i].stall;
      redirect         = vecs[i].redir;
      redirect_pc      = vecs[i].rpc;
      bus.imem_ack     = vecs[i].ack;
      bus.imem_rdata   = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].addr);
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].valid, vecs[i].pc2, vecs[i].instr);
      @(negedge clk);
    end

    // Reset asserted mid-cycle while in DROP, with a stale ack arriving afterwards.
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("rst async req", {31'd0, bus.imem_req}, 32'd0);
    check_outputs("rst async", 1'b0, 32'h0, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4 ^ K;
    @(posedge clk);
    #1;
    check_outputs("rst held", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    #1;
    chk("post-rst idle req", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    check_outputs("post-rst stale ack", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    bus.imem_rdata = 32'h0 ^ K;
    #1;
    chk("restart req", {31'd0, bus.imem_req}, 32'd1);
    chk("restart addr", bus.imem_addr, 32'h0);
    @(posedge clk);
    #1;
    check_outputs("restart", 1'b1, 32'h0, 32'h0 ^ K);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
